// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: fetch FSM states, line-count width and line alignment.
package instr_fetch_pkg;

  localparam int MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEMAND   = 2'd1,
    PREFETCH = 2'd2
  } fetch_state_e;

  // Width able to hold the demand line count of one packet (1 .. FETCH/LINE+1).
  function automatic int line_cnt_w(input int fetch_bytes, input int line_bytes);
    return $clog2(fetch_bytes / line_bytes + 2);
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] line_align(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int line_log2);
    return (addr >> line_log2) << line_log2;
  endfunction

endpackage

// File: rtl/fetch_credit_ctr.sv
// Saturating up/down credit counter with a full flag; shared by the fetch-stage units.
module fetch_credit_ctr #(
  parameter int MAX_COUNT = 4,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  assign full = (count == CNT_W'(MAX_COUNT));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_prefetch_aligner.sv
// Splits fetch packets into line-aligned demand requests plus sequential lookahead prefetches.
// Build option: PF_CONF_FILTER_EN suppresses prefetch for low-confidence speculative packets.
module instr_prefetch_aligner
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH      = 48,
  parameter int LINE_BYTES      = 64,
  parameter int FETCH_BYTES     = 128,
  parameter int LOOKAHEAD       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CONF_W          = 2,
  parameter int CONF_THRESH     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   fetch_valid,
  output logic                                   fetch_ready,
  input  logic [ADDR_WIDTH-1:0]                  fetch_addr,
  input  logic                                   fetch_spec,
  input  logic [CONF_W-1:0]                      fetch_conf,
  input  logic                                   flush,
  output logic                                   req_valid,
  input  logic                                   req_ready,
  output logic [ADDR_WIDTH-1:0]                  req_addr,
  output logic                                   req_is_pf,
  input  logic                                   resp_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

  localparam int LINE_LOG2 = $clog2(LINE_BYTES);
  localparam int CNT_W_RAW = line_cnt_w(FETCH_BYTES, LINE_BYTES);
  localparam int CNT_W     = (CNT_W_RAW < 2) ? 2 : CNT_W_RAW;
  localparam int PF_W      = (LOOKAHEAD > 0) ? $clog2(LOOKAHEAD + 1) : 1;
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(LINE_BYTES);

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q;
  logic [CNT_W-1:0]        dem_left_q;
  logic [PF_W-1:0]         pf_left_q;
  logic [ADDR_WIDTH-1:0]   last_line_q;
  logic                    last_vld_q;

  logic [ADDR_WIDTH-1:0]   fetch_base;
  logic [LINE_LOG2-1:0]    fetch_off;
  logic [31:0]             span;
  logic [CNT_W-1:0]        n_lines;
  logic [CNT_W-1:0]        n_eff;
  logic                    skip_first;
  logic [ADDR_WIDTH-1:0]   start_addr;
  logic [PF_W-1:0]         pf_init;
  logic                    accept;
  logic                    req_hs;
  logic                    credit_full;

  // Packet decode: aligned base, number of lines touched, optional skip of a repeated line.
  assign fetch_base = ADDR_WIDTH'(line_align(MAX_ADDR_W'(fetch_addr), LINE_LOG2));
  assign fetch_off  = fetch_addr[LINE_LOG2-1:0];
  assign span       = 32'(fetch_off) + 32'(FETCH_BYTES + LINE_BYTES - 1);
  assign n_lines    = CNT_W'(span >> LINE_LOG2);
  assign skip_first = last_vld_q && (fetch_base == last_line_q);
  assign n_eff      = n_lines - CNT_W'(skip_first);
  assign start_addr = skip_first ? fetch_base + LINE_STEP : fetch_base;

`ifdef PF_CONF_FILTER_EN
  assign pf_init = (!fetch_spec || (fetch_conf >= CONF_W'(CONF_THRESH))) ? PF_W'(LOOKAHEAD) : '0;
`else
  logic unused_conf;
  assign unused_conf = ^{fetch_spec, fetch_conf, CONF_W'(CONF_THRESH)};
  assign pf_init     = PF_W'(LOOKAHEAD);
`endif

  // Handshakes; flush and reset mask both sides combinationally.
  assign fetch_ready = (state_q == IDLE) && !flush && !rst;
  assign accept      = fetch_valid && fetch_ready;
  assign req_valid   = (state_q != IDLE) && !credit_full && !flush && !rst;
  assign req_hs      = req_valid && req_ready;
  assign req_addr    = cur_addr_q;
  assign req_is_pf   = (state_q == PREFETCH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (n_eff != '0)        state_d = DEMAND;
          else if (pf_init != '0) state_d = PREFETCH;
        end
      end
      DEMAND: begin
        if (req_hs && (dem_left_q == CNT_W'(1)))
          state_d = (pf_left_q != '0) ? PREFETCH : IDLE;
      end
      PREFETCH: begin
        if (req_hs && (pf_left_q == PF_W'(1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Issue register: current line address and remaining demand/prefetch counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      dem_left_q <= '0;
      pf_left_q  <= '0;
      last_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        dem_left_q <= '0;
        pf_left_q  <= '0;
        last_vld_q <= 1'b0;
      end else if (accept) begin
        cur_addr_q <= start_addr;
        dem_left_q <= n_eff;
        pf_left_q  <= pf_init;
      end else if (req_hs) begin
        cur_addr_q <= cur_addr_q + LINE_STEP;
        if (state_q == DEMAND) begin
          dem_left_q  <= dem_left_q - CNT_W'(1);
          last_line_q <= cur_addr_q;
          last_vld_q  <= 1'b1;
        end else begin
          pf_left_q <= pf_left_q - PF_W'(1);
        end
      end
    end
  end

  fetch_credit_ctr #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .CNT_W     (OUT_W)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (req_hs),
    .dec   (resp_valid),
    .count (outstanding),
    .full  (credit_full)
  );

endmodule

// File: tb/tb_instr_prefetch_aligner.sv
// Scoreboard bench for instr_prefetch_aligner: directed packets, queued expected requests.
module tb_instr_prefetch_aligner;
  localparam int AW = 48;

  logic          clk = 1'b0;
  logic          rst, fetch_valid, fetch_ready, fetch_spec, flush;
  logic          req_valid, req_ready, req_is_pf, resp_valid;
  logic [AW-1:0] fetch_addr, req_addr;
  logic [1:0]    fetch_conf;
  logic [2:0]    outstanding;
  logic          auto_resp, man_resp;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          pf;
  } req_t;

  req_t exp_q[$];
  req_t mon_e;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  assign resp_valid = auto_resp ? (outstanding != 3'd0) : man_resp;

  instr_prefetch_aligner dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_addr  (fetch_addr),
    .fetch_spec  (fetch_spec),
    .fetch_conf  (fetch_conf),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_is_pf   (req_is_pf),
    .resp_valid  (resp_valid),
    .outstanding (outstanding)
  );

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic pf);
    req_t e;
    e.addr = a;
    e.pf   = pf;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one packet, then checks the first request appears the cycle after accept.
  task automatic do_fetch(input logic [AW-1:0] a, input logic s, input logic [1:0] c,
                          input string name);
    int n;
    n = 0;
    while (!fetch_ready && n < 500) begin
      tick();
      n++;
    end
    chk({name, "_ready"}, AW'(fetch_ready), AW'(1));
    fetch_valid = 1'b1;
    fetch_addr  = a;
    fetch_spec  = s;
    fetch_conf  = c;
    tick();
    fetch_valid = 1'b0;
    chk({name, "_first_valid"}, AW'(req_valid), AW'(1));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !fetch_ready || outstanding != 3'd0) && n < 500) begin
      tick();
      n++;
    end
    chk({name, "_pending"}, AW'(exp_q.size()), AW'(0));
    chk({name, "_outstanding"}, AW'(outstanding), AW'(0));
  endtask

  // Monitor: every accepted request must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_req: got 0x%0h, expected no request", req_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("req_addr", req_addr, mon_e.addr);
        chk("req_is_pf", AW'(req_is_pf), AW'(mon_e.pf));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_addr = '0; fetch_spec = 1'b0; fetch_conf = 2'd0;
    flush = 1'b0; req_ready = 1'b1; auto_resp = 1'b1; man_resp = 1'b0;
    repeat (3) tick();
    chk("rst_fetch_ready", AW'(fetch_ready), AW'(0));
    chk("rst_req_valid", AW'(req_valid), AW'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_fetch_ready", AW'(fetch_ready), AW'(1));
    chk("post_rst_req_addr", req_addr, AW'(0));
    chk("post_rst_req_is_pf", AW'(req_is_pf), AW'(0));
    chk("post_rst_outstanding", AW'(outstanding), AW'(0));

    // Aligned packet: two demand lines then two prefetch lines back to back.
    push(48'h1000, 1'b0); push(48'h1040, 1'b0); push(48'h1080, 1'b1); push(48'h10C0, 1'b1);
    do_fetch(48'h1000, 1'b0, 2'd0, "t1");
    for (int i = 0; i < 4; i++) begin
      chk("t1_back_to_back", AW'(req_valid), AW'(1));
      tick();
    end
    chk("t1_ready_return", AW'(fetch_ready), AW'(1));
    chk("t1_valid_drop", AW'(req_valid), AW'(0));
    wait_idle("t1");

    // Repeated line is filtered: 0x1040 was the last demand line.
    push(48'h1080, 1'b0); push(48'h10C0, 1'b1); push(48'h1100, 1'b1);
    do_fetch(48'h1040, 1'b0, 2'd0, "t6a");
    wait_idle("t6a");

    // Unaligned packet with two cycles of backpressure on the first line.
    push(48'h1000, 1'b0); push(48'h1040, 1'b0); push(48'h1080, 1'b0);
    push(48'h10C0, 1'b1); push(48'h1100, 1'b1);
    do_fetch(48'h1010, 1'b0, 2'd0, "t2");
    req_ready = 1'b0;
    tick();
    chk("t2_hold_valid", AW'(req_valid), AW'(1));
    chk("t2_hold_addr", req_addr, 48'h1000);
    tick();
    chk("t2_hold_addr2", req_addr, 48'h1000);
    req_ready = 1'b1;
    wait_idle("t2");

    // Low-confidence speculative packet.
    push(48'h2000, 1'b0); push(48'h2040, 1'b0);
`ifndef PF_CONF_FILTER_EN
    push(48'h2080, 1'b1); push(48'h20C0, 1'b1);
`endif
    do_fetch(48'h2000, 1'b1, 2'd1, "t3");
    wait_idle("t3");

    // High-confidence speculative packet prefetches in every build.
    push(48'h2400, 1'b0); push(48'h2440, 1'b0); push(48'h2480, 1'b1); push(48'h24C0, 1'b1);
    do_fetch(48'h2400, 1'b1, 2'd3, "t3b");
    wait_idle("t3b");

    // Credit stall at four outstanding; one response releases the fifth request.
    auto_resp = 1'b0;
    man_resp  = 1'b0;
    push(48'h1000, 1'b0); push(48'h1040, 1'b0); push(48'h1080, 1'b0);
    push(48'h10C0, 1'b1); push(48'h1100, 1'b1);
    do_fetch(48'h1010, 1'b0, 2'd0, "t4");
    repeat (4) tick();
    chk("t4_stall_valid", AW'(req_valid), AW'(0));
    chk("t4_stall_outstanding", AW'(outstanding), AW'(4));
    tick();
    chk("t4_stall_hold", AW'(req_valid), AW'(0));
    man_resp = 1'b1;
    tick();
    man_resp = 1'b0;
    chk("t4_release_valid", AW'(req_valid), AW'(1));
    chk("t4_release_addr", req_addr, 48'h1100);
    auto_resp = 1'b1;
    wait_idle("t4");

    // Flush on the first prefetch cycle; credits survive, filter is cleared.
    auto_resp = 1'b0;
    push(48'h3000, 1'b0); push(48'h3040, 1'b0);
    do_fetch(48'h3000, 1'b0, 2'd0, "t5");
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("t5_flush_req_valid", AW'(req_valid), AW'(0));
    chk("t5_flush_fetch_ready", AW'(fetch_ready), AW'(0));
    tick();
    flush = 1'b0;
    #1;
    chk("t5_after_flush_ready", AW'(fetch_ready), AW'(1));
    chk("t5_after_flush_outstanding", AW'(outstanding), AW'(2));
    chk("t5_after_flush_valid", AW'(req_valid), AW'(0));
    push(48'h3040, 1'b0); push(48'h3080, 1'b0); push(48'h30C0, 1'b1); push(48'h3100, 1'b1);
    auto_resp = 1'b1;
    do_fetch(48'h3040, 1'b0, 2'd0, "t5b");
    wait_idle("t5b");

    // Address wrap at the top of the 48-bit space.
    push(48'hFFFF_FFFF_FFC0, 1'b0); push(48'h0, 1'b0); push(48'h40, 1'b0);
    push(48'h80, 1'b1); push(48'hC0, 1'b1);
    do_fetch(48'hFFFF_FFFF_FFF0, 1'b0, 2'd0, "t6b");
    wait_idle("t6b");

    repeat (3) tick();
    chk("sb_empty", AW'(exp_q.size()), AW'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
